serial_comparator_ctrl: RTL
===========================

# serial_comparator_ctrl

Bit-serial magnitude comparator controller. Captures two WIDTH-bit unsigned operands on a start pulse and walks them MSB-first through a single 1-bit comparator cell, one bit per clock. It terminates early at the first differing bit and reports greater/equal/less with a one-cycle done pulse. It sequences the team's 1-bit comparator so that wide compares reuse one small cell instead of a full parallel comparator.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request a compare; accepted only in IDLE
- a  in  WIDTH  operand A, sampled on the accepting edge
- b  in  WIDTH  operand B, sampled on the accepting edge
- busy  out  1  high in COMPARE and DONE
- done  out  1  one-cycle pulse, results valid
- gt  out  1  A > B
- eq  out  1  A == B
- lt  out  1  A < B
- nbits  out  $clog2(WIDTH+1)  number of bits examined in the last compare

## Operation
- Asynchronous rst drives all outputs to 0, the state to IDLE, and the shift registers and counter to 0.
- FSM states are IDLE, COMPARE and DONE.
- IDLE + start=1: load sa←a, sb←b, cnt←0; clear gt/eq/lt/nbits; go to COMPARE.
- IDLE + start=0: stay in IDLE.
- COMPARE: the cell compares sa[WIDTH-1] vs sb[WIDTH-1].
  - Bits differ: gt←(sa msb=1), lt←(sb msb=1), nbits←cnt+1, go to DONE.
  - Bits equal and cnt==WIDTH-1: eq←1, nbits←WIDTH, go to DONE.
  - Bits equal otherwise: sa,sb shift left by 1 (zero fill), cnt←cnt+1, stay in COMPARE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start in COMPARE or DONE is ignored; no queueing.
- gt/eq/lt/nbits hold their values from DONE until the next accepted start clears them. After the first compare exactly one of gt/eq/lt is high.
- The a/b inputs are don't-care outside the accepting edge.
- Reset mid-compare aborts immediately with no done pulse.

## Timing
- start accepted at edge of cycle T; bit WIDTH-1 is compared in cycle T+1.
- First difference at MSB-relative index j (0..WIDTH-1): done is high in cycle T+2+j and nbits=j+1.
- Equal operands: done is high in cycle T+WIDTH+1 and nbits=WIDTH.
- Minimum latency is 2 cycles; maximum is WIDTH+1 cycles.
- busy rises in T+1 and falls in the cycle after done; the next start is accepted no earlier than the cycle after done.
- Results (gt/eq/lt/nbits) are registered and change only on the edge entering DONE or on an accepted start.
- The cell is purely combinational between the shift-register MSBs and the FSM next-state logic. There are no multicycle paths.

## Structure
- Shared header comparator_defs.vh holds the state encodings (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and the result-flag bit positions.
- Sub-module bit_compare_cell is the 1-bit comparator: inputs a_bit, b_bit; outputs gt_bit, lt_bit (equal = neither). It is instantiated once.
- The top holds the FSM, the two WIDTH-bit shift registers, the counter, and the result registers.

## Test plan
- WIDTH=8, a=8'hA5, b=8'h25, start at T → done at T+2, gt=1, eq=0, lt=0, nbits=1.
- a=8'h3C, b=8'h3D → done at T+9, lt=1, nbits=8. Also a=8'h5A, b=8'h5A → done at T+9, eq=1, nbits=8.
- a=8'h40, b=8'h60 (j=2) → done at T+4, lt=1, nbits=3. Hold start high throughout: exactly one done pulse, new compare accepted the cycle after done.
- start pulsed with new operands during COMPARE → ignored; result matches the original operands.
- Assert rst in cycle T+3 of an 8-bit equal compare → all outputs 0 immediately, no done. After release, a=8'h01, b=8'h00 → done at T'+9, gt=1, nbits=8.

Source files
------------

// File: rtl/serial_comparator_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encodings and the bit positions of the result flags.
package serial_comparator_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int RES_GT = 0;
    localparam int RES_EQ = 1;
    localparam int RES_LT = 2;
    localparam int RES_W  = 3;

    typedef logic [RES_W-1:0] result_flags_t;

endpackage

// File: rtl/serial_comparator_ctrl_bit_compare_cell.sv
// Single-bit magnitude comparator cell. Equality is signalled by
// neither output being high.
module bit_compare_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic gt_bit,
    output logic lt_bit
);

    // Purely combinational compare of one bit pair
    always_comb begin
        gt_bit = a_bit & ~b_bit;
        lt_bit = ~a_bit & b_bit;
    end

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Bit-serial magnitude comparator controller. Walks two captured
// operands MSB-first through one bit_compare_cell, stopping at the
// first differing bit, and reports gt/eq/lt with a one-cycle done.
module serial_comparator_ctrl
    import serial_comparator_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       eq,
    output logic                       lt,
    output logic [$clog2(WIDTH+1)-1:0] nbits
);

    localparam int NBW = $clog2(WIDTH+1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shiftA_q, shiftA_d;
    logic [WIDTH-1:0] shiftB_q, shiftB_d;
    logic [NBW-1:0]   cnt_q,    cnt_d;
    logic [NBW-1:0]   nbits_q,  nbits_d;
    result_flags_t    flags_q,  flags_d;

    logic cellGt;
    logic cellLt;

    bit_compare_cell uCell (
        .a_bit  (shiftA_q[WIDTH-1]),
        .b_bit  (shiftB_q[WIDTH-1]),
        .gt_bit (cellGt),
        .lt_bit (cellLt)
    );

    // Next-state, shift and result logic for the IDLE/COMPARE/DONE sequence
    always_comb begin
        state_d  = state_q;
        shiftA_d = shiftA_q;
        shiftB_d = shiftB_q;
        cnt_d    = cnt_q;
        nbits_d  = nbits_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shiftA_d = a;
                    shiftB_d = b;
                    cnt_d    = '0;
                    nbits_d  = '0;
                    flags_d  = '0;
                    state_d  = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (cellGt || cellLt) begin
                    flags_d         = '0;
                    flags_d[RES_GT] = cellGt;
                    flags_d[RES_LT] = cellLt;
                    nbits_d         = cnt_q + NBW'(1);
                    state_d         = ST_DONE;
                end else if (cnt_q == NBW'(WIDTH-1)) begin
                    flags_d         = '0;
                    flags_d[RES_EQ] = 1'b1;
                    nbits_d         = NBW'(WIDTH);
                    state_d         = ST_DONE;
                end else begin
                    shiftA_d = {shiftA_q[WIDTH-2:0], 1'b0};
                    shiftB_d = {shiftB_q[WIDTH-2:0], 1'b0};
                    cnt_d    = cnt_q + NBW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand, counter and result registers with async clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shiftA_q <= '0;
            shiftB_q <= '0;
            cnt_q    <= '0;
            nbits_q  <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            shiftA_q <= shiftA_d;
            shiftB_q <= shiftB_d;
            cnt_q    <= cnt_d;
            nbits_q  <= nbits_d;
            flags_q  <= flags_d;
        end
    end

    // Status and result outputs decoded from registered state
    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        gt    = flags_q[RES_GT];
        eq    = flags_q[RES_EQ];
        lt    = flags_q[RES_LT];
        nbits = nbits_q;
    end

endmodule
